// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode classes, fetch FSM states, default vector addresses.
// FETCH_INTR_EN adds the interrupt-vector fetch state.
package cpu_pkg;

  // Upper nibble marking a two-byte (opcode + immediate) instruction.
  localparam logic [3:0] OP_TWO_BYTE = 4'hC;

  localparam logic [7:0] DEF_RESET_VEC_ADDR = 8'h00;
  localparam logic [7:0] DEF_INTR_VEC_ADDR  = 8'h01;

  typedef enum logic [1:0] {
    StResetVec,
    StFetch,
    StFetchImm
`ifdef FETCH_INTR_EN
    , StIntrVec
`endif
  } fetch_state_e;

  function automatic logic is_two_byte(input logic [7:0] op);
    return op[7:4] == OP_TWO_BYTE;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, immediate, next-PC and valid flag.
// Clear drops valid only (bubble/flush); hold freezes everything.
module if_id_reg #(
  parameter int unsigned PC_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_hold,
  input  logic            i_clear,
  input  logic [7:0]      i_instr,
  input  logic [7:0]      i_imm,
  input  logic [PC_W-1:0] i_pc_next,
  output logic [7:0]      o_instr,
  output logic [7:0]      o_imm,
  output logic [PC_W-1:0] o_pc_next,
  output logic            o_valid
);

  logic [7:0]      r_instr;
  logic [7:0]      r_imm;
  logic [PC_W-1:0] r_pc_next;
  logic            r_valid;

  // Pipeline register update: reset > clear > load (unless held).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instr   <= '0;
      r_imm     <= '0;
      r_pc_next <= '0;
      r_valid   <= 1'b0;
    end else if (i_clear) begin
      r_valid   <= 1'b0;
    end else if (i_load && !i_hold) begin
      r_instr   <= i_instr;
      r_imm     <= i_imm;
      r_pc_next <= i_pc_next;
      r_valid   <= 1'b1;
    end
  end

  assign o_instr   = r_instr;
  assign o_imm     = r_imm;
  assign o_pc_next = r_pc_next;
  assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register. Assembles one- and two-byte
// instructions, handles reset vector, stall and redirect.
// FETCH_INTR_EN adds interrupt request/ack and the interrupt-vector fetch.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned    PC_W           = 8,
  parameter logic [PC_W-1:0] RESET_VEC_ADDR = PC_W'(DEF_RESET_VEC_ADDR)
`ifdef FETCH_INTR_EN
  , parameter logic [PC_W-1:0] INTR_VEC_ADDR = PC_W'(DEF_INTR_VEC_ADDR)
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic [7:0]      i_imem_rdata,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic [7:0]      o_if_id_instr,
  output logic [7:0]      o_if_id_imm,
  output logic [PC_W-1:0] o_if_id_pc_next,
  output logic            o_if_id_valid
`ifdef FETCH_INTR_EN
  , input  logic            i_intr_req
  , output logic            o_intr_ack
  , output logic [PC_W-1:0] o_intr_ret_pc
`endif
);

  fetch_state_e    r_state, w_state_d;
  logic [PC_W-1:0] r_pc, w_pc_d;
  logic [7:0]      r_opcode, w_opcode_d;

  logic            w_load, w_hold, w_clear;
  logic [7:0]      w_instr, w_imm;
  logic [PC_W-1:0] w_pc_inc, w_rdata_pc;

`ifdef FETCH_INTR_EN
  logic            r_intr_ack, w_intr_ack_d;
  logic [PC_W-1:0] r_intr_ret_pc, w_intr_ret_pc_d;
  logic            r_pending, w_pending_d;
`endif

  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_rdata_pc = PC_W'(i_imem_rdata);

  // State register; reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StResetVec;
      r_pc          <= '0;
      r_opcode      <= '0;
`ifdef FETCH_INTR_EN
      r_intr_ack    <= 1'b0;
      r_intr_ret_pc <= '0;
      r_pending     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_opcode      <= w_opcode_d;
`ifdef FETCH_INTR_EN
      r_intr_ack    <= w_intr_ack_d;
      r_intr_ret_pc <= w_intr_ret_pc_d;
      r_pending     <= w_pending_d;
`endif
    end
  end

  // Memory address selection from state/PC only.
  always_comb begin
    o_imem_addr = r_pc;
    case (r_state)
      StResetVec: o_imem_addr = RESET_VEC_ADDR;
`ifdef FETCH_INTR_EN
      StIntrVec:  o_imem_addr = INTR_VEC_ADDR;
`endif
      default:    o_imem_addr = r_pc;
    endcase
  end

  // Next-state and IF/ID control: redirect > stall > normal fetch.
  always_comb begin
    w_state_d  = r_state;
    w_pc_d     = r_pc;
    w_opcode_d = r_opcode;
    w_load     = 1'b0;
    w_hold     = 1'b0;
    w_clear    = 1'b0;
    w_instr    = i_imem_rdata;
    w_imm      = 8'h00;
`ifdef FETCH_INTR_EN
    w_intr_ack_d    = 1'b0;
    w_intr_ret_pc_d = r_intr_ret_pc;
    // Request pulses are latched even while stalled so none is lost.
    w_pending_d     = r_pending | i_intr_req;
`endif
    if (i_redirect) begin
      w_pc_d    = i_redirect_pc;
      w_state_d = StFetch;
      w_clear   = 1'b1;
    end else if (i_stall) begin
      w_hold = 1'b1;
    end else begin
      case (r_state)
        StResetVec: begin
          w_pc_d    = w_rdata_pc;
          w_state_d = StFetch;
          w_hold    = 1'b1;
        end
        StFetch: begin
`ifdef FETCH_INTR_EN
          if (r_pending || i_intr_req) begin
            w_intr_ret_pc_d = r_pc;
            w_intr_ack_d    = 1'b1;
            w_pending_d     = 1'b0;
            w_clear         = 1'b1;
            w_state_d       = StIntrVec;
          end else
`endif
          if (is_two_byte(i_imem_rdata)) begin
            w_opcode_d = i_imem_rdata;
            w_pc_d     = w_pc_inc;
            w_state_d  = StFetchImm;
            w_clear    = 1'b1;
          end else begin
            w_load = 1'b1;
            w_pc_d = w_pc_inc;
          end
        end
        StFetchImm: begin
          w_instr   = r_opcode;
          w_imm     = i_imem_rdata;
          w_load    = 1'b1;
          w_pc_d    = w_pc_inc;
          w_state_d = StFetch;
        end
`ifdef FETCH_INTR_EN
        StIntrVec: begin
          w_pc_d    = w_rdata_pc;
          w_state_d = StFetch;
          w_hold    = 1'b1;
        end
`endif
        default: w_state_d = StResetVec;
      endcase
    end
  end

  if_id_reg #(
    .PC_W (PC_W)
  ) u_if_id_reg (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_hold    (w_hold),
    .i_clear   (w_clear),
    .i_instr   (w_instr),
    .i_imm     (w_imm),
    .i_pc_next (w_pc_inc),
    .o_instr   (o_if_id_instr),
    .o_imm     (o_if_id_imm),
    .o_pc_next (o_if_id_pc_next),
    .o_valid   (o_if_id_valid)
  );

`ifdef FETCH_INTR_EN
  assign o_intr_ack    = r_intr_ack;
  assign o_intr_ret_pc = r_intr_ret_pc;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected IF/ID contents.
// Define FETCH_INTR_EN to also exercise the interrupt path.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_imm;
  logic [7:0] if_id_pc_next;
  logic       if_id_valid;
`ifdef FETCH_INTR_EN
  logic       intr_req;
  logic       intr_ack;
  logic [7:0] intr_ret_pc;
`endif

  logic [7:0] mem [256];
  assign imem_rdata = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .o_imem_addr     (imem_addr),
    .i_imem_rdata    (imem_rdata),
    .i_stall         (stall),
    .i_redirect      (redirect),
    .i_redirect_pc   (redirect_pc),
    .o_if_id_instr   (if_id_instr),
    .o_if_id_imm     (if_id_imm),
    .o_if_id_pc_next (if_id_pc_next),
    .o_if_id_valid   (if_id_valid)
`ifdef FETCH_INTR_EN
    , .i_intr_req    (intr_req)
    , .o_intr_ack    (intr_ack)
    , .o_intr_ret_pc (intr_ret_pc)
`endif
  );

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc_next;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the current IF/ID contents against the oldest expected instruction.
  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(if_id_valid), 32'd1);
      chk({tag, "_instr"}, 32'(if_id_instr), 32'(e.instr));
      chk({tag, "_imm"}, 32'(if_id_imm), 32'(e.imm));
      chk({tag, "_pc_next"}, 32'(if_id_pc_next), 32'(e.pc_next));
    end
  endtask

  // Advance until IF/ID holds a valid instruction, bounded by budget cycles.
  task automatic expect_next(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_id_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (found) pop_cmp(tag);
    else chk({tag, "_timeout"}, 32'(found), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
`ifdef FETCH_INTR_EN
    intr_req    = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
    mem[8'h00] = 8'h10;
    mem[8'h10] = 8'h21;
    mem[8'h11] = 8'hC1;
    mem[8'h12] = 8'h5A;
    mem[8'h13] = 8'h33;
    mem[8'h14] = 8'h44;
    mem[8'h15] = 8'h55;
    mem[8'h16] = 8'hC7;
    mem[8'h17] = 8'h99;
    mem[8'h40] = 8'h66;
    mem[8'hFF] = 8'hC0;

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", 32'(if_id_instr), 32'd0);
    chk("rst_imm", 32'(if_id_imm), 32'd0);
    chk("rst_pc_next", 32'(if_id_pc_next), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h00);
    rst = 1'b0;

    // Cycle 1: reset vector read, still a bubble.
    @(negedge clk);
    chk("resetvec_valid", 32'(if_id_valid), 32'd0);
    chk("resetvec_pc", 32'(imem_addr), 32'h10);

    sb.push_back('{8'h21, 8'h00, 8'h11});
    sb.push_back('{8'hC1, 8'h5A, 8'h13});
    sb.push_back('{8'h33, 8'h00, 8'h14});
    // Cycle 2: first instruction lands in IF/ID.
    @(negedge clk);
    pop_cmp("first_instr");
    @(negedge clk);
    chk("two_byte_bubble", 32'(if_id_valid), 32'd0);
    @(negedge clk);
    pop_cmp("two_byte");
    @(negedge clk);
    pop_cmp("after_two_byte");

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(if_id_valid), 32'd1);
      chk("stall_instr", 32'(if_id_instr), 32'h33);
      chk("stall_pc_next", 32'(if_id_pc_next), 32'h14);
      chk("stall_pc", 32'(imem_addr), 32'h14);
    end
    stall = 1'b0;

    sb.push_back('{8'h44, 8'h00, 8'h15});
    sb.push_back('{8'h55, 8'h00, 8'h16});
    expect_next("post_stall_a", 4);
    expect_next("post_stall_b", 4);

    // Opcode 0xC7 is fetched next; redirect while its immediate is pending.
    @(negedge clk);
    chk("partial_bubble", 32'(if_id_valid), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    stall       = 1'b1;
    @(negedge clk);
    chk("redirect_flush", 32'(if_id_valid), 32'd0);
    chk("redirect_target", 32'(imem_addr), 32'h40);
    redirect = 1'b0;
    stall    = 1'b0;
    sb.push_back('{8'h66, 8'h00, 8'h41});
    @(negedge clk);
    pop_cmp("redirect_instr");

    // Wrap-around: two-byte opcode at 0xFF, immediate at 0x00.
    mem[8'h00]  = 8'h07;
    redirect    = 1'b1;
    redirect_pc = 8'hFF;
    @(negedge clk);
    chk("wrap_flush", 32'(if_id_valid), 32'd0);
    redirect = 1'b0;
    sb.push_back('{8'hC0, 8'h07, 8'h01});
    sb.push_back('{8'h01, 8'h00, 8'h02});
    expect_next("wrap", 4);
    expect_next("after_wrap", 4);

`ifdef FETCH_INTR_EN
    mem[8'h01] = 8'h80;
    mem[8'h20] = 8'h12;
    mem[8'h80] = 8'h77;
    mem[8'h30] = 8'hC5;
    mem[8'h31] = 8'h11;
    redirect    = 1'b1;
    redirect_pc = 8'h20;
    @(negedge clk);
    redirect = 1'b0;
    intr_req = 1'b1;
    @(negedge clk);
    intr_req = 1'b0;
    chk("intr_ack", 32'(intr_ack), 32'd1);
    chk("intr_ret_pc", 32'(intr_ret_pc), 32'h20);
    chk("intr_bubble", 32'(if_id_valid), 32'd0);
    chk("intr_vec_addr", 32'(imem_addr), 32'h01);
    @(negedge clk);
    chk("intr_ack_pulse", 32'(intr_ack), 32'd0);
    chk("isr_pc", 32'(imem_addr), 32'h80);
    sb.push_back('{8'h77, 8'h00, 8'h81});
    @(negedge clk);
    pop_cmp("isr_instr");

    // Request during FETCH_IMM waits for the immediate.
    redirect    = 1'b1;
    redirect_pc = 8'h30;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    chk("defer_bubble", 32'(if_id_valid), 32'd0);
    intr_req = 1'b1;
    sb.push_back('{8'hC5, 8'h11, 8'h32});
    @(negedge clk);
    intr_req = 1'b0;
    pop_cmp("defer_instr");
    chk("defer_no_ack", 32'(intr_ack), 32'd0);
    @(negedge clk);
    chk("defer_ack", 32'(intr_ack), 32'd1);
    chk("defer_ret_pc", 32'(intr_ret_pc), 32'h32);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage plus IF/ID pipeline register. Owns the PC, reads bytes from instruction memory, and assembles one- or two-byte instructions. Presents each instruction (opcode byte, immediate byte, PC of next instruction) to the decode stage and control unit. Handles the reset vector, stall, branch/flush redirect, and optionally the interrupt vector.

## Interface
- PC_W, 8: PC and instruction memory address width; PC arithmetic wraps modulo 2^PC_W.
- RESET_VEC_ADDR, 8'h00: memory address that holds the start PC.
- INTR_VEC_ADDR, 8'h01: memory address that holds the ISR PC (used only with the interrupt feature).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  PC_W  instruction memory address; combinational from state/PC.
- imem_rdata  in  8  instruction memory data; asynchronous read, valid in the same cycle as imem_addr.
- stall  in  1  hazard unit hold; freezes PC, state and IF/ID.
- redirect  in  1  branch/jump/call/ret taken; flush and refetch.
- redirect_pc  in  PC_W  redirect target.
- if_id_instr  out  8  opcode byte to decode.
- if_id_imm  out  8  second byte of a two-byte instruction, else 0.
- if_id_pc_next  out  PC_W  address following the full instruction (CALL return address).
- if_id_valid  out  1  IF/ID holds a real instruction; 0 = bubble.
- intr_req  in  1  interrupt request pulse. Present only with FETCH_INTR_EN.
- intr_ack  out  1  one-cycle pulse when the interrupt is taken. Present only with FETCH_INTR_EN.
- intr_ret_pc  out  PC_W  PC to resume at after RTI. Present only with FETCH_INTR_EN.

## Operation
- States: RESET_VEC, FETCH, FETCH_IMM, INTR_VEC (INTR_VEC exists only with the macro).
- Two-byte detection: imem_rdata[7:4] == OP_TWO_BYTE (4'hC, all ra values).
- Reset (rst=1): takes priority over all inputs.
  - state<=RESET_VEC, pc<=0.
  - if_id_instr/imm/pc_next <= 0, if_id_valid<=0.
  - intr_ack<=0, intr_ret_pc<=0, pending<=0.
- RESET_VEC: imem_addr=RESET_VEC_ADDR; pc<=imem_rdata; state<=FETCH; if_id_valid stays 0.
- FETCH: imem_addr=pc.
  - One-byte opcode: if_id_instr<=rdata, if_id_imm<=0, if_id_pc_next<=pc+1, if_id_valid<=1, pc<=pc+1.
  - Two-byte opcode: opcode buffered internally, pc<=pc+1, state<=FETCH_IMM, if_id_valid<=0 (bubble).
- FETCH_IMM: imem_addr=pc; if_id_instr<=buffered opcode, if_id_imm<=rdata, if_id_pc_next<=pc+1, if_id_valid<=1, pc<=pc+1, state<=FETCH.
- Priority below reset: redirect > stall > normal.
  - redirect: pc<=redirect_pc, state<=FETCH, if_id_valid<=0. Discards a half-fetched two-byte instruction and overrides stall.
  - stall (no redirect): every register holds, including if_id_*.
- Wrap-around: PC 0xFF increments to 0x00. A two-byte instruction at 0xFF takes its immediate from 0x00 and reports if_id_pc_next=0x01.

## Timing
- Fetch-to-IF/ID latency is 1 cycle for one-byte instructions and 2 cycles for two-byte instructions, with one bubble between.
- After rst deasserts: cycle 1 = RESET_VEC; the first valid instruction appears in IF/ID at the end of cycle 2.
- Redirect: target byte is fetched in the cycle after redirect; IF/ID is valid at the end of that cycle.
- Outputs are registered, except imem_addr, which is combinational.

## Configuration
- FETCH_INTR_EN defined:
  - intr_req sets a pending bit.
  - Interrupt is taken in FETCH when (pending|intr_req) and no stall and no redirect. Never taken in FETCH_IMM or RESET_VEC.
  - On take: intr_ret_pc<=pc, intr_ack=1 for one cycle, if_id_valid<=0, pending<=0, state<=INTR_VEC.
  - INTR_VEC: imem_addr=INTR_VEC_ADDR, pc<=rdata, state<=FETCH.
  - A request arriving while in INTR_VEC re-sets pending.
- FETCH_INTR_EN undefined: the three interrupt ports and the INTR_VEC state are absent; behaviour is otherwise identical.

## Structure
- Shared package cpu_pkg:
  - OP_TWO_BYTE = 4'hC.
  - fetch state enum.
  - Default vector address constants.
- One sub-module, if_id_reg: holds instr/imm/pc_next/valid, with load, hold (stall) and clear (bubble/flush) controls.

## Test plan
- Reset: mem[0]=0x10, mem[0x10]=0x21. Release rst → cycle 2 IF/ID = {0x21, imm 0, pc_next 0x11, valid 1}.
- Two-byte: mem[0x10]=0xC1, mem[0x11]=0x5A → one bubble, then {0xC1, 0x5A, pc_next 0x12, valid 1}.
- Stall 3 cycles mid-stream → pc and IF/ID unchanged for 3 cycles, then resume without lost or duplicated instructions.
- Redirect to 0x40 during FETCH_IMM, stall also high → valid 0, next cycle fetches 0x40, partial 0xC? opcode discarded.
- Wrap: 0xC0 at 0xFF, 0x07 at 0x00 → {0xC0, 0x07, pc_next 0x01}.
- FETCH_INTR_EN: mem[1]=0x80, intr_req at pc 0x20 → intr_ack one cycle, intr_ret_pc=0x20, next valid instruction from 0x80. intr_req during FETCH_IMM is deferred until the immediate completes.
